// File: rtl/muldiv_sched_pkg.sv
// Shared types and constants for the multiply/divide scheduler.
package md_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } md_state_e;

  // Captured operation kind.
  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  // Restoring divider iteration count for 32-bit operands.
  localparam int DIV_ITERS = 32;

  // Two's-complement magnitude of a 32-bit value when sgn is set.
  function automatic logic [31:0] md_abs(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/muldiv_sched_if.sv
// E-stage side of the multiply/divide scheduler: decode, operands, flush,
// stall and HI/LO results.
// Handshake: an op is offered whenever ex_valid_i is high with a decode bit
// set; it is taken in that cycle when stall_o is low and flush_i is low.
// stall_o is the only back-pressure and is purely combinational.
interface muldiv_sched_if;
  logic        ex_valid_i;
  logic        ex_div_i;
  logic        ex_divu_i;
  logic        ex_mult_i;
  logic        ex_multu_i;
  logic        ex_mthi_i;
  logic        ex_mtlo_i;
  logic        ex_mfhi_i;
  logic        ex_mflo_i;
  logic [31:0] src_a_i;
  logic [31:0] src_b_i;
  logic        flush_i;
  logic        stall_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport slave (
    input  ex_valid_i, ex_div_i, ex_divu_i, ex_mult_i, ex_multu_i,
    input  ex_mthi_i, ex_mtlo_i, ex_mfhi_i, ex_mflo_i,
    input  src_a_i, src_b_i, flush_i,
    output stall_o, busy_o, done_o, hi_o, lo_o
  );

  modport master (
    output ex_valid_i, ex_div_i, ex_divu_i, ex_mult_i, ex_multu_i,
    output ex_mthi_i, ex_mtlo_i, ex_mfhi_i, ex_mflo_i,
    output src_a_i, src_b_i, flush_i,
    input  stall_o, busy_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_sched_div_core.sv
// Iterative restoring divider datapath: unsigned magnitudes in, one
// quotient bit per enabled step, MSB first.
module md_div_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_step,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic [31:0] o_quo,
  output logic [31:0] o_rem
);
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dvs;
  logic [32:0] w_rem_sh;
  logic [32:0] w_diff;
  logic        w_qbit;

  // Shift the next dividend bit in and try subtracting the divisor.
  always_comb begin
    w_rem_sh = {r_rem, r_quo[31]};
    w_diff   = w_rem_sh - {1'b0, r_dvs};
    w_qbit   = ~w_diff[32];
  end

  // Load magnitudes on start, otherwise restore-or-keep one step per enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
    end else if (i_load) begin
      r_rem <= '0;
      r_quo <= i_dividend;
      r_dvs <= i_divisor;
    end else if (i_step) begin
      r_rem <= w_qbit ? w_diff[31:0] : w_rem_sh[31:0];
      r_quo <= {r_quo[30:0], w_qbit};
    end
  end

  assign o_quo = r_quo;
  assign o_rem = r_rem;
endmodule

// File: rtl/muldiv_sched.sv
// Multiply/divide scheduler and HI/LO owner beside the E-stage ALU.
module muldiv_sched
  import md_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input  logic         clk,
  input  logic         resetn,
  muldiv_sched_if.slave bus,
  output md_state_e    dbg_state_o
);
  localparam logic [7:0] MUL_LAST = 8'(MUL_LAT - 1);
  localparam logic [7:0] DIV_LAST = 8'(DIV_ITERS - 1);
  localparam int         PD       = (MUL_LAT > 1) ? (MUL_LAT - 1) : 1;

  md_state_e   r_state, w_next;
  md_op_e      r_op, w_start_op;
  logic [7:0]  r_cnt;
  logic [31:0] r_a, r_b, r_hi, r_lo;
  logic [63:0] r_pipe [PD];
  logic        w_is_mul, w_is_div, w_start, w_mt_ok, w_busy, w_done, w_stall;
  logic        w_signed, w_neg_q, w_neg_r;
  logic [63:0] w_ea, w_eb, w_prod, w_mul_res;
  logic [31:0] w_quo, w_rem, w_q_fix, w_r_fix;

  // Decode and start qualification for the op offered in E.
  always_comb begin
    w_is_mul   = bus.ex_mult_i | bus.ex_multu_i;
    w_is_div   = bus.ex_div_i | bus.ex_divu_i;
    w_start    = (r_state == IDLE) & bus.ex_valid_i & (w_is_mul | w_is_div) & ~bus.flush_i;
    w_mt_ok    = (r_state == IDLE) & bus.ex_valid_i & ~bus.flush_i;
    w_start_op = bus.ex_mult_i  ? MD_MULT  :
                 bus.ex_multu_i ? MD_MULTU :
                 bus.ex_div_i   ? MD_DIV   : MD_DIVU;
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Next-state: sequence the op; a flush while busy abandons it.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = w_is_mul ? MUL : DIV;
      MUL:     if (r_cnt == MUL_LAST) w_next = IDLE;
      DIV:     if (r_cnt == DIV_LAST) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (bus.flush_i && (r_state != IDLE)) w_next = IDLE;
  end

  // Outputs: busy, result-write pulse and E-stage stall.
  always_comb begin
    w_busy  = (r_state != IDLE);
    w_done  = ~bus.flush_i & (((r_state == MUL) && (r_cnt == MUL_LAST)) || (r_state == FIX));
    w_stall = w_busy & bus.ex_valid_i &
              (w_is_mul | w_is_div | bus.ex_mthi_i | bus.ex_mtlo_i | bus.ex_mfhi_i | bus.ex_mflo_i);
  end

  // Capture operands on start and count busy cycles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_a   <= '0;
      r_b   <= '0;
      r_op  <= MD_MULT;
      r_cnt <= '0;
    end else if (w_start) begin
      r_a   <= bus.src_a_i;
      r_b   <= bus.src_b_i;
      r_op  <= w_start_op;
      r_cnt <= '0;
    end else if (w_busy) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Product of captured operands, sign- or zero-extended to 64 bits.
  always_comb begin
    w_signed = (r_op == MD_MULT) | (r_op == MD_DIV);
    w_ea     = {{32{w_signed & r_a[31]}}, r_a};
    w_eb     = {{32{w_signed & r_b[31]}}, r_b};
    w_prod   = w_ea * w_eb;
    w_mul_res = (MUL_LAT == 1) ? w_prod : r_pipe[PD-1];
  end

  // Product pipeline; retiming spreads the multiplier across these stages.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < PD; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= w_prod;
      for (int i = 1; i < PD; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  md_div_core u_div (
    .clk        (clk),
    .rst_n      (resetn),
    .i_load     (w_start & w_is_div),
    .i_step     (r_state == DIV),
    .i_dividend (md_abs(bus.src_a_i, bus.ex_div_i)),
    .i_divisor  (md_abs(bus.src_b_i, bus.ex_div_i)),
    .o_quo      (w_quo),
    .o_rem      (w_rem)
  );

  // Sign fix: quotient negative when signs differ, remainder follows dividend.
  always_comb begin
    w_neg_q = (r_op == MD_DIV) & (r_a[31] ^ r_b[31]);
    w_neg_r = (r_op == MD_DIV) & r_a[31];
    w_q_fix = w_neg_q ? (32'd0 - w_quo) : w_quo;
    w_r_fix = w_neg_r ? (32'd0 - w_rem) : w_rem;
  end

  // HI/LO: result write on done, otherwise MTHI/MTLO while idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_done) begin
      if (r_state == MUL) begin
        r_hi <= w_mul_res[63:32];
        r_lo <= w_mul_res[31:0];
      end else if (r_b == 32'd0) begin
        r_hi <= r_a;
        r_lo <= 32'hFFFF_FFFF;
      end else begin
        r_hi <= w_r_fix;
        r_lo <= w_q_fix;
      end
    end else if (w_mt_ok) begin
      if (bus.ex_mthi_i) r_hi <= bus.src_a_i;
      if (bus.ex_mtlo_i) r_lo <= bus.src_a_i;
    end
  end

  assign bus.stall_o  = w_stall;
  assign bus.busy_o   = w_busy;
  assign bus.done_o   = w_done;
  assign bus.hi_o     = r_hi;
  assign bus.lo_o     = r_lo;
  assign dbg_state_o  = r_state;
endmodule

// File: doc/muldiv_sched.md
# muldiv_sched

Multi-cycle multiply/divide scheduler and HI/LO register owner for the MIPS32 pipeline. It sits beside the E-stage ALU and accepts MULT/MULTU/DIV/DIVU, MTHI/MTLO and MFHI/MFLO from the E stage. It sequences a pipelined multiplier and an iterative radix-2 divider, and stalls the E stage while a dependent instruction must wait. HI/LO are architectural state held only here.

## Interface
- MUL_LAT, 3: multiplier latency in cycles (≥1); busy cycles for MULT/MULTU.
- DIV_ITERS, 32: divider iterations; fixed at 32 for MIPS32.
- clk  in  1  clock, all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ex_valid_i  in  1  E-stage instruction valid (not a bubble).
- ex_div_i, ex_divu_i, ex_mult_i, ex_multu_i  in  1 each  one-hot op decode from the E-stage control bus.
- ex_mthi_i, ex_mtlo_i, ex_mfhi_i, ex_mflo_i  in  1 each  HI/LO move decode.
- src_a_i  in  32  forwarded rs value.
- src_b_i  in  32  forwarded rt value.
- flush_i  in  1  squash: abort the in-flight op and block any start this cycle.
- stall_o  out  1  hold the E stage (combinational).
- busy_o  out  1  operation in flight.
- done_o  out  1  one-cycle pulse on the HI/LO result write.
- hi_o, lo_o  out  32 each  current HI/LO registers.

## Operation
- States: IDLE, MUL, DIV, FIX.
- An op is a multiply/divide decode with ex_valid_i=1.
- Start: accepted when state==IDLE, an op is present and flush_i=0.
  - Operands are captured.
  - Sign is recorded for signed ops.
  - Counter is cleared.
- IDLE→MUL for MULT/MULTU.
- IDLE→DIV for DIV/DIVU; the divider is loaded with |a| and |b| (signed) or a and b (unsigned).
- MUL: counter increments each cycle. When it reaches MUL_LAT-1, HI/LO ← 64-bit product (signed or unsigned), done_o=1, next state IDLE.
- DIV: one restoring step per cycle. After DIV_ITERS steps, next state FIX.
- FIX: applies signs. Quotient is negated if the operand signs differ; remainder takes the sign of the dividend. Then LO←quotient, HI←remainder, done_o=1, next state IDLE.
- Divide by zero is deterministic and takes the full latency:
  - DIVU: LO=0xFFFFFFFF, HI=a.
  - DIV: the same raw values, with no sign fix.
- 0x80000000 / -1 (DIV): LO=0x80000000, HI=0.
- MTHI/MTLO in IDLE with ex_valid_i=1 and flush_i=0: HI or LO ← src_a_i at the end of the cycle.
- busy_o = (state≠IDLE).
- stall_o = busy_o & ex_valid_i & (any muldiv op | mthi | mtlo | mfhi | mflo). Instructions that do not use HI/LO never stall.
- MFHI/MFLO read hi_o/lo_o directly when not stalled.
- flush_i while busy: state→IDLE next cycle, HI/LO unchanged, no done_o.
  - The pipeline raises flush_i only when the issuing instruction is squashed.
- flush_i together with a start or MT*: no state change.
- Reset: state=IDLE, counter=0, HI=LO=0, busy_o=0, done_o=0, stall_o=0 regardless of the other inputs.
  - Reset mid-operation discards the operation.

## Timing
- Start accepted in cycle T.
- Multiply:
  - MUL during T+1..T+MUL_LAT.
  - HI/LO written at the edge ending T+MUL_LAT and visible on hi_o/lo_o at T+MUL_LAT+1.
  - busy_o high for exactly MUL_LAT cycles.
- Divide:
  - DIV during T+1..T+32, FIX at T+33.
  - Result visible at T+34.
  - busy_o high for 33 cycles.
- done_o is high in the last busy cycle.
- A dependent instruction in E sees stall_o deassert in the first IDLE cycle and proceeds that cycle with the new HI/LO.
- Back-to-back ops: the second op starts in the first IDLE cycle; there are no idle bubbles beyond that.
- MTHI/MTLO: single-cycle, 0 busy.

## Structure
- Package md_pkg holds:
  - the state enum (IDLE/MUL/DIV/FIX);
  - the op encoding (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU);
  - the constant DIV_ITERS=32.
- Sub-module md_div_core is the iterative restoring divider datapath: remainder/quotient shift registers with a one-step enable.
- The multiplier is a registered product inside muldiv_sched, retimed across MUL_LAT stages.

## Test plan
- MULT 0xFFFFFFFF×0x00000002 → HI=0xFFFFFFFF, LO=0xFFFFFFFE, visible at T+4. MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. busy_o high for exactly 33 cycles, done_o at T+33.
- DIVU 100/0 → LO=0xFFFFFFFF, HI=100. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU issued, then MFLO in E at T+1 → stall_o=1 for cycles T+1..T+33 and releases at T+34 with the correct LO. An ADDU in E during busy is not stalled.
- MTHI 0x1234 at idle, then DIV started and flush_i pulsed at T+10 → busy_o=0 at T+11, HI=0x1234, no done_o.
- resetn low at T+5 of a MULT → all outputs 0 immediately. A new MULT after release completes normally.
